robot_world_model: RTL
======================

// Module: robot_world_model
// PURPOSE
//  Grid-world model that closes the loop around the mealy robot controller.
//  Consumes the controller's front/rotate commands, tracks the robot's cell and heading on a
//  GRID_W x GRID_H grid with blocked cells, and drives head/left wall sensors back to it.
//  Used by benches for autonomous maze runs; all outputs are Moore (state only), so no comb loop.
// PARAMETERS
//  GRID_W     4        grid width in cells (x = 0..GRID_W-1, x grows east)
//  GRID_H     4        grid height in cells (y = 0..GRID_H-1, y grows north)
//  WALL_MAP   '0       GRID_W*GRID_H bits; bit[y*GRID_W+x]=1 -> cell blocked
//  START_X    0        reset x
//  START_Y    0        reset y
//  START_DIR  2'd0     reset heading (N=0, E=1, S=2, W=3)
//  GOAL_X     GRID_W-1 goal x
//  GOAL_Y     GRID_H-1 goal y
//  CNT_W      16       width of move/collision counters
// PORTS
//  clk         in   1                 clock, rising edge
//  rst_n       in   1                 synchronous reset, active-low
//  front       in   1                 command: advance one cell
//  rotate      in   1                 command: turn 90 deg clockwise
//  head        out  1                 cell ahead blocked or off-grid
//  left        out  1                 cell to the left blocked or off-grid
//  pos_x       out  $clog2(GRID_W)    current x
//  pos_y       out  $clog2(GRID_H)    current y
//  dir         out  2                 current heading
//  collision   out  1                 1-cycle pulse: front issued into blocked cell
//  illegal     out  1                 1-cycle pulse: front and rotate both high
//  at_goal     out  1                 sticky: goal reached since reset
//  move_count  out  CNT_W             successful advances, saturating
//  coll_count  out  CNT_W             collisions, saturating
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pos=(START_X,START_Y), dir=START_DIR, counters=0,
//    collision=illegal=0, at_goal=(START==GOAL). Reset wins over any command, mid-run too.
//  - Commands sampled every posedge; effect visible the same edge (1-cycle latency).
//  - {front,rotate}=00: hold. 01: dir<=dir+1 mod 4 (N->E->S->W->N), pos held.
//    10: if head==0 -> pos<=ahead cell, move_count++; else pos held, collision=1, coll_count++.
//    11: no state change, illegal=1, counters unchanged.
//  - Neighbour offsets: N (0,+1), E (+1,0), S (0,-1), W (-1,0); left = heading (dir+3) mod 4.
//  - head/left combinational from registered pos/dir only: 1 if target outside grid
//    (x<0, x>=GRID_W, y<0, y>=GRID_H) or WALL_MAP bit set. Off-grid check precedes indexing;
//    never wrap coordinates.
//  - at_goal sets on the edge pos becomes (GOAL_X,GOAL_Y); stays set until reset; motion continues.
//  - Counters saturate at all-ones (no wrap).
//  - Start cell blocked in WALL_MAP: not checked; model starts there regardless.
// STRUCTURE
//  - robot_pkg: heading constants DIR_N/E/S/W, dir_t typedef, cmd encoding (CMD_IDLE/ROT/FWD/ILL).
//  - Sub-module robot_cell_probe: (x,y,dir) -> blocked flag + neighbour coords; instantiated
//    twice (ahead, left). Top holds pos/dir/flags/counters registers.
// TESTING (4x4, WALL_MAP=0 except cell (1,1) blocked, start (0,0) N, goal (3,3))
//  1 Reset -> pos(0,0) dir=0 head=0 left=1 move_count=0 at_goal=0.
//  2 front x3 -> pos(0,3), move_count=3, head=1; 4th front -> collision pulse, pos(0,3), coll_count=1.
//  3 From reset: rotate x4 -> dir 1,2,3,0; pos held; from (0,1) N after 1 rotate (E) -> head=1 ((1,1) blocked).
//  4 front=rotate=1 one cycle -> illegal pulse, pos/dir/counters unchanged next cycle.
//  5 Path R, F, F, F, L-via-3R, F, F, F from (0,0) -> reaches (3,3), at_goal=1, stays 1 after moving off.
//  6 rst_n=0 mid-path with front=1 -> pos(0,0) dir=0 counters 0; running mealy_robot loop
//    for 200 cycles: no illegal pulse, pos always in-grid.

Source files
------------

// File: rtl/robot_pkg.sv
// Shared heading and command encodings for the grid-world robot model.
// Also holds the clockwise-turn helper and the port-width rule for coordinates.
package robot_pkg;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;

  // {front, rotate}
  typedef enum logic [1:0] {
    CMD_IDLE = 2'b00,
    CMD_ROT  = 2'b01,
    CMD_FWD  = 2'b10,
    CMD_ILL  = 2'b11
  } cmd_t;

  function automatic logic [1:0] turn_cw(input logic [1:0] d, input logic [1:0] steps);
    return d + steps;
  endfunction

  // Coordinate width; a 1-cell dimension still gets a 1-bit port.
  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/robot_cell_probe.sv
// Neighbour lookup: (x,y,dir) -> neighbour coords and blocked flag. Pure combinational.
// Off-grid is decided on signed coordinates before the wall map is indexed, so nothing wraps.
module robot_cell_probe
  import robot_pkg::*;
#(
  parameter int                         GRID_W   = 4,
  parameter int                         GRID_H   = 4,
  parameter logic [GRID_W*GRID_H-1:0]   WALL_MAP = '0,
  parameter int                         XW       = coord_w(GRID_W),
  parameter int                         YW       = coord_w(GRID_H)
) (
  input  logic [XW-1:0] x,
  input  logic [YW-1:0] y,
  input  logic [1:0]    dir,
  output logic          blocked,
  output logic [XW-1:0] nx,
  output logic [YW-1:0] ny
);

  int tx;
  int ty;
  int idx;
  logic off_grid;

  always_comb begin
    tx       = int'(x);
    ty       = int'(y);
    blocked  = 1'b0;
    case (dir_t'(dir))
      DIR_N:   ty = ty + 1;
      DIR_E:   tx = tx + 1;
      DIR_S:   ty = ty - 1;
      default: tx = tx - 1;
    endcase
    off_grid = (tx < 0) || (tx >= GRID_W) || (ty < 0) || (ty >= GRID_H);
    idx      = ty * GRID_W + tx;
    if (off_grid) begin
      blocked = 1'b1;
    end else begin
      for (int i = 0; i < GRID_W * GRID_H; i++) begin
        if (i == idx) blocked = WALL_MAP[i];
      end
    end
    nx = tx[XW-1:0];
    ny = ty[YW-1:0];
  end

endmodule

// File: rtl/robot_world_model.sv
// Grid-world model closing the loop around a robot controller; commands take effect on the
// sampling edge (1-cycle latency), no backpressure, all outputs are registered or derived from registers.
module robot_world_model
  import robot_pkg::*;
#(
  parameter int                         GRID_W    = 4,
  parameter int                         GRID_H    = 4,
  parameter logic [GRID_W*GRID_H-1:0]   WALL_MAP  = '0,
  parameter int                         START_X   = 0,
  parameter int                         START_Y   = 0,
  parameter logic [1:0]                 START_DIR = 2'd0,
  parameter int                         GOAL_X    = GRID_W - 1,
  parameter int                         GOAL_Y    = GRID_H - 1,
  parameter int                         CNT_W     = 16,
  parameter int                         XW        = coord_w(GRID_W),
  parameter int                         YW        = coord_w(GRID_H)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             front,
  input  logic             rotate,
  output logic             head,
  output logic             left,
  output logic [XW-1:0]    pos_x,
  output logic [YW-1:0]    pos_y,
  output logic [1:0]       dir,
  output logic             collision,
  output logic             illegal,
  output logic             at_goal,
  output logic [CNT_W-1:0] move_count,
  output logic [CNT_W-1:0] coll_count
);

  localparam logic [XW-1:0] SX = XW'(START_X);
  localparam logic [YW-1:0] SY = YW'(START_Y);
  localparam logic [XW-1:0] GX = XW'(GOAL_X);
  localparam logic [YW-1:0] GY = YW'(GOAL_Y);
  localparam logic          START_AT_GOAL = (START_X == GOAL_X) && (START_Y == GOAL_Y);

  logic [XW-1:0] ahead_x;
  logic [YW-1:0] ahead_y;
  logic [XW-1:0] left_x_unused;
  logic [YW-1:0] left_y_unused;
  logic [1:0]    left_dir;

  assign left_dir = turn_cw(dir, 2'd3);

  robot_cell_probe #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .WALL_MAP(WALL_MAP), .XW(XW), .YW(YW)
  ) u_probe_ahead (
    .x(pos_x), .y(pos_y), .dir(dir),
    .blocked(head), .nx(ahead_x), .ny(ahead_y)
  );

  robot_cell_probe #(
    .GRID_W(GRID_W), .GRID_H(GRID_H), .WALL_MAP(WALL_MAP), .XW(XW), .YW(YW)
  ) u_probe_left (
    .x(pos_x), .y(pos_y), .dir(left_dir),
    .blocked(left), .nx(left_x_unused), .ny(left_y_unused)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos_x      <= SX;
      pos_y      <= SY;
      dir        <= START_DIR;
      collision  <= 1'b0;
      illegal    <= 1'b0;
      at_goal    <= START_AT_GOAL;
      move_count <= '0;
      coll_count <= '0;
    end else begin
      collision <= 1'b0;
      illegal   <= 1'b0;
      case (cmd_t'({front, rotate}))
        CMD_ROT: dir <= turn_cw(dir, 2'd1);
        CMD_FWD: begin
          if (!head) begin
            pos_x <= ahead_x;
            pos_y <= ahead_y;
            if (move_count != {CNT_W{1'b1}}) move_count <= move_count + 1'b1;
            if ((ahead_x == GX) && (ahead_y == GY)) at_goal <= 1'b1;
          end else begin
            collision <= 1'b1;
            if (coll_count != {CNT_W{1'b1}}) coll_count <= coll_count + 1'b1;
          end
        end
        CMD_ILL: illegal <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule
